// File: rtl/apb_cfg_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_master_pkg
// Description : Shared definitions for the cfg register APB initiator:
//               register map, bus widths, master FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_cfg_master_pkg;

  localparam int REG_ADDRWIDTH = 8;
  localparam int REG_DATAWIDTH = 32;

  // cfg register map
  localparam logic [REG_ADDRWIDTH-1:0] REG_STDN_TPU_ADDR   = 8'h00;
  localparam logic [REG_ADDRWIDTH-1:0] REG_MATRIX_A_ADDR   = 8'h04;
  localparam logic [REG_ADDRWIDTH-1:0] REG_MATRIX_B_ADDR   = 8'h08;
  localparam logic [REG_ADDRWIDTH-1:0] REG_MATRIX_C_ADDR   = 8'h0C;
  localparam logic [REG_ADDRWIDTH-1:0] REG_BATCH_SIZE_ADDR = 8'h10;

  // master FSM states
  typedef enum logic [2:0] {
    M_IDLE   = 3'd0,
    M_SETUP  = 3'd1,
    M_ACCESS = 3'd2,
    M_WAIT   = 3'd3,
    M_GAP    = 3'd4
  } m_state_t;

  // A poll completes once any masked bit reads back as 1.
  function automatic logic poll_hit(input logic [REG_DATAWIDTH-1:0] data,
                                    input logic [REG_DATAWIDTH-1:0] mask);
    return (data & mask) != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : apb_cycle_counter
// Description : Loadable down-counter with a zero flag. Load has priority
//               over decrement; decrement saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_master
// Description : APB initiator for the cfg register slave. Turns one command
//               into one APB write or read, returns read data, and can poll
//               a register until any masked bit is set.
//               Optional feature macro: APB_TIMEOUT_EN (abort an ACCESS
//               phase after TIMEOUT_CYCLES cycles without PREADY).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cfg_master
  import apb_cfg_master_pkg::*;
#(
  parameter int unsigned POLL_GAP       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic                     cmd_poll,
  input  logic [REG_ADDRWIDTH-1:0] cmd_addr,
  input  logic [REG_DATAWIDTH-1:0] cmd_wdata,
  output logic                     rsp_valid,
  output logic [REG_DATAWIDTH-1:0] rsp_rdata,
  output logic                     rsp_err,
  output logic [REG_ADDRWIDTH-1:0] PADDR,
  output logic                     PWRITE,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic [REG_DATAWIDTH-1:0] PWDATA,
  input  logic [REG_DATAWIDTH-1:0] PRDATA,
  input  logic                     PREADY
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);

  m_state_t                 state_q, state_d;
  logic [REG_ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [REG_DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic [REG_DATAWIDTH-1:0] mask_q, mask_d;
  logic                     poll_q, poll_d;
  logic                     cmd_ready_q, cmd_ready_d;

  logic                     w_gap_load;
  logic                     w_gap_dec;
  logic                     w_gap_zero;
  logic                     w_timeout_hit;
  logic                     w_rsp_fire;
  logic                     w_rsp_err;
  logic [REG_DATAWIDTH-1:0] w_rsp_data;

  // Idle spacing between poll reads; loaded with POLL_GAP-1 so WAIT lasts
  // exactly POLL_GAP cycles.
  apb_cycle_counter #(
    .WIDTH (GAP_W)
  ) u_gap_cnt (
    .clk        (PCLK),
    .rst        (PRESET),
    .i_load     (w_gap_load),
    .i_load_val (GAP_W'(POLL_GAP - 1)),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Cleared on every SETUP, counts PREADY-low ACCESS cycles; zero flag marks
  // the TIMEOUT_CYCLES-th such cycle.
  apb_cycle_counter #(
    .WIDTH (TO_W)
  ) u_timeout_cnt (
    .clk        (PCLK),
    .rst        (PRESET),
    .i_load     (state_q == M_SETUP),
    .i_load_val (TO_W'(TIMEOUT_CYCLES - 1)),
    .i_dec      ((state_q == M_ACCESS) && !PREADY),
    .o_zero     (w_timeout_hit)
  );
`else
  // No timeout hardware: ACCESS waits for PREADY indefinitely. The parameter
  // only selects between two identical tie-offs so it stays referenced.
  if (TIMEOUT_CYCLES >= 1) begin : g_no_timeout
    assign w_timeout_hit = 1'b0;
  end else begin : g_no_timeout_zero
    assign w_timeout_hit = 1'b0;
  end
`endif

  // Next-state, command latch and response generation.
  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    mask_d     = mask_q;
    poll_d     = poll_q;
    w_gap_load = 1'b0;
    w_gap_dec  = 1'b0;
    w_rsp_fire = 1'b0;
    w_rsp_err  = 1'b0;
    w_rsp_data = '0;
    case (state_q)
      M_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          mask_d   = cmd_wdata;
          poll_d   = cmd_poll & ~cmd_write;
          state_d  = M_SETUP;
        end
      end
      M_SETUP: begin
        state_d = M_ACCESS;
      end
      M_ACCESS: begin
        // PREADY takes precedence over a timeout landing in the same cycle.
        if (PREADY) begin
          if (poll_q && !poll_hit(PRDATA, mask_q)) begin
            w_gap_load = 1'b1;
            state_d    = M_WAIT;
          end else begin
            w_rsp_fire = 1'b1;
            w_rsp_data = pwrite_q ? '0 : PRDATA;
            state_d    = M_GAP;
          end
        end else if (w_timeout_hit) begin
          w_rsp_fire = 1'b1;
          w_rsp_err  = 1'b1;
          state_d    = M_GAP;
        end
      end
      M_WAIT: begin
        if (w_gap_zero) begin
          state_d = M_SETUP;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      M_GAP: begin
        state_d = M_IDLE;
      end
      default: begin
        state_d = M_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == M_IDLE);
  end

  // State and command registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= M_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      mask_q      <= '0;
      poll_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      mask_q      <= mask_d;
      poll_q      <= poll_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = (state_q == M_SETUP) || (state_q == M_ACCESS);
  assign PENABLE   = (state_q == M_ACCESS);

  // A transfer cut short by reset must not report a completion.
  assign rsp_valid = w_rsp_fire & ~PRESET;
  assign rsp_err   = w_rsp_err & ~PRESET;
  assign rsp_rdata = PRESET ? '0 : w_rsp_data;

endmodule
`default_nettype wire
